// File: rtl/ip_csum_insert.sv
// ip_csum_insert: buffers one IPv4 header arriving on a 16-bit AXIS stream,
// accumulates the one's-complement header checksum while it arrives, then
// replays the header with the checksum word replaced by the computed value.
//
// Ports:
//   clk, areset                  clock, asynchronous active-high reset
//   axis_i_tready/tvalid/tlast/tdata   header input (16-bit, network order)
//   axis_o_tready/tvalid/tlast/tdata   header output, checksum substituted
//   overflow                     one-cycle pulse when a header was truncated
module ip_csum_insert #(
    parameter int unsigned MAX_WORDS = 30,
    parameter int unsigned CSUM_IDX  = 5
) (
    input  logic        clk,
    input  logic        areset,
    output logic        axis_i_tready,
    input  logic        axis_i_tvalid,
    input  logic        axis_i_tlast,
    input  logic [15:0] axis_i_tdata,
    input  logic        axis_o_tready,
    output logic        axis_o_tvalid,
    output logic        axis_o_tlast,
    output logic [15:0] axis_o_tdata,
    output logic        overflow
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ACC_W  = DATA_W + 1;
    localparam int unsigned CNT_W  = $clog2(MAX_WORDS + 1);

    typedef enum logic [1:0] {
        ST_FILL,
        ST_FOLD,
        ST_DRAIN
    } state_t;

    state_t              state_q,    state_d;
    logic [CNT_W-1:0]    count_q,    count_d;
    logic [CNT_W-1:0]    idx_q,      idx_d;
    logic [ACC_W-1:0]    acc_q,      acc_d;
    logic                trunc_q,    trunc_d;
    logic [DATA_W-1:0]   csum_q,     csum_d;
    logic                tready_q,   tready_d;
    logic                tvalid_q,   tvalid_d;
    logic                tlast_q,    tlast_d;
    logic [DATA_W-1:0]   tdata_q,    tdata_d;
    logic                overflow_q, overflow_d;

    logic [DATA_W-1:0]   hdr_mem [MAX_WORDS];
    logic                mem_we;
    logic [DATA_W-1:0]   word_eff;
    logic                in_fire;
    logic                out_fire;

    assign axis_i_tready = tready_q;
    assign axis_o_tvalid = tvalid_q;
    assign axis_o_tlast  = tlast_q;
    assign axis_o_tdata  = tdata_q;
    assign overflow      = overflow_q;

    assign in_fire  = axis_i_tvalid && tready_q;
    assign out_fire = tvalid_q && axis_o_tready;

    // The checksum field itself never contributes to the sum.
    assign word_eff = (count_q == CNT_W'(CSUM_IDX)) ? '0 : axis_i_tdata;

    // Next-state and output computation.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        idx_d      = idx_q;
        acc_d      = acc_q;
        trunc_d    = trunc_q;
        csum_d     = csum_q;
        tready_d   = tready_q;
        tvalid_d   = tvalid_q;
        tlast_d    = tlast_q;
        tdata_d    = tdata_q;
        overflow_d = 1'b0;
        mem_we     = 1'b0;

        unique case (state_q)
            ST_FILL: begin
                if (in_fire) begin
                    if (count_q < CNT_W'(MAX_WORDS)) begin
                        mem_we  = 1'b1;
                        count_d = count_q + CNT_W'(1);
                        // End-around carry folded in on every beat keeps acc in 17 bits.
                        acc_d   = ACC_W'(word_eff) + ACC_W'(acc_q[DATA_W-1:0])
                                + ACC_W'(acc_q[DATA_W]);
                    end else begin
                        trunc_d = 1'b1;
                    end
                    if (axis_i_tlast) begin
                        state_d    = ST_FOLD;
                        tready_d   = 1'b0;
                        // Registered so the pulse lines up with the FOLD cycle.
                        overflow_d = trunc_q || (count_q >= CNT_W'(MAX_WORDS));
                    end
                end
            end

            ST_FOLD: begin
                // acc never exceeds 0x1fffe, so this add cannot wrap.
                csum_d  = ~(acc_q[DATA_W-1:0] + DATA_W'(acc_q[DATA_W]));
                trunc_d = 1'b0;
                idx_d   = '0;
                state_d = ST_DRAIN;
            end

            ST_DRAIN: begin
                if (out_fire && tlast_q) begin
                    state_d  = ST_FILL;
                    count_d  = '0;
                    acc_d    = '0;
                    tvalid_d = 1'b0;
                    tlast_d  = 1'b0;
                    tready_d = 1'b1;
                end else if ((!tvalid_q || axis_o_tready) && (idx_q < count_q)) begin
                    tvalid_d = 1'b1;
                    tdata_d  = (idx_q == CNT_W'(CSUM_IDX)) ? csum_q : hdr_mem[idx_q];
                    tlast_d  = (idx_q == CNT_W'(count_q - CNT_W'(1)));
                    idx_d    = idx_q + CNT_W'(1);
                end else if (out_fire) begin
                    tvalid_d = 1'b0;
                end
            end

            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q    <= ST_FILL;
            count_q    <= '0;
            idx_q      <= '0;
            acc_q      <= '0;
            trunc_q    <= 1'b0;
            csum_q     <= '0;
            tready_q   <= 1'b1;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            tdata_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            acc_q      <= acc_d;
            trunc_q    <= trunc_d;
            csum_q     <= csum_d;
            tready_q   <= tready_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
            tdata_q    <= tdata_d;
            overflow_q <= overflow_d;
        end
    end

    // Header buffer; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            hdr_mem[count_q] <= axis_i_tdata;
        end
    end

endmodule
